// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract. Each stage resolves one CW-bit chunk and
// registers the chunk carry; the operands and the partial sum ride along with
// the token so later stages find their chunk in the token itself.
// A single global enable stalls every stage together when the result is not taken.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic         clk,
  input logic         rst,
  adder_pipe_if.slave bus
);

  localparam int CW = WIDTH / STAGES;

  logic                          en;
  logic [STAGES-1:0][WIDTH-1:0]  a_q;
  logic [STAGES-1:0][WIDTH-1:0]  bp_q;
  logic [STAGES-1:0][WIDTH-1:0]  s_q;
  logic [STAGES-1:0]             c_q;
  logic [STAGES-1:0]             v_q;

  // The pipe only moves as a whole; a held result freezes everything behind it.
  assign en           = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] bp_i;
    logic [WIDTH-1:0] s_i;
    logic             c_i;
    logic             v_i;
    logic [CW:0]      chunk;
    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] bp_r;
    logic [WIDTH-1:0] s_r;
    logic             c_r;
    logic             v_r;

    if (k == 0) begin : g_head
      // Subtract is a + ~b + 1: invert b once here and force the first carry in.
      assign a_i  = bus.a;
      assign bp_i = bus.sub ? ~bus.b : bus.b;
      assign s_i  = '0;
      assign c_i  = bus.sub | bus.ci;
      assign v_i  = bus.in_valid;
    end else begin : g_body
      assign a_i  = a_q[k-1];
      assign bp_i = bp_q[k-1];
      assign s_i  = s_q[k-1];
      assign c_i  = c_q[k-1];
      assign v_i  = v_q[k-1];
    end

    assign chunk = {1'b0, a_i[k*CW +: CW]} + {1'b0, bp_i[k*CW +: CW]} + (CW+1)'(c_i);

    // Splice this stage's chunk result into the partial sum travelling with the token.
    always_comb begin
      s_nxt = s_i;
      s_nxt[k*CW +: CW] = chunk[CW-1:0];
    end

    // Stage register: loads on every enabled edge, bubbles included, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_r  <= '0;
        bp_r <= '0;
        s_r  <= '0;
        c_r  <= 1'b0;
        v_r  <= 1'b0;
      end else if (en) begin
        a_r  <= a_i;
        bp_r <= bp_i;
        s_r  <= s_nxt;
        c_r  <= chunk[CW];
        v_r  <= v_i;
      end
    end

    assign a_q[k]  = a_r;
    assign bp_q[k] = bp_r;
    assign s_q[k]  = s_r;
    assign c_q[k]  = c_r;
    assign v_q[k]  = v_r;
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.s         = s_q[STAGES-1];
  assign bus.co        = c_q[STAGES-1];
  // Signed overflow: operands agree in sign but the result does not.
  assign bus.ovf       = (a_q[STAGES-1][WIDTH-1] == bp_q[STAGES-1][WIDTH-1]) &&
                         (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit ripple adder (sum, carry-out, a, b, carry-in).
- Splits a WIDTH-bit add/subtract into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages.
- Adds valid/ready flow control on both sides, a subtract mode and signed-overflow reporting.
- Sits in the datapath wherever a wide adder must close timing at the system clock.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- STAGES, 4, pipeline depth. Legal values are 1..WIDTH with WIDTH % STAGES == 0. Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set on a/b/ci/sub is valid.
- in_ready  output  1  block accepts an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in; used in add mode only.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  s/co/ovf hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- s  output  WIDTH  sum or difference.
- co  output  1  carry-out (add); carry-out = NOT borrow (sub).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: every stage valid bit = 0, out_valid = 0, s = 0, co = 0, ovf = 0, in_ready = 1.
- Arithmetic, add (sub=0): {co,s} = a + b + ci, computed at WIDTH+1 bits.
- Arithmetic, subtract (sub=1): {co,s} = a + ~b + 1; ci is ignored. co=1 means a >= b unsigned.
- Overflow: ovf = (a[W-1] == b'[W-1]) && (s[W-1] != a[W-1]), where b' is b in add mode and ~b in subtract mode.
- Stage k (0..STAGES-1) adds bits [k*CW +: CW] of a and b' plus the carry registered by stage k-1; stage 0 takes ci, or 1 in subtract mode.
- Unprocessed upper operand chunks and completed lower sum chunks travel with the token in shift registers.
- Global stall: en = !out_valid || out_ready; in_ready = en.
  - When en = 0, every stage register, including its valid bit, holds.
  - When en = 1, all stages advance by one.
- Transfer occurs on a rising edge with in_valid && in_ready. A token advances even when in_valid = 0, as a bubble (valid bit 0).
- Latency: a set accepted at edge t presents out_valid = 1 with its result after edge t+STAGES-1, i.e. STAGES cycles, when there are no stalls. Throughput is 1 result per cycle.
- Holding: out_valid and s/co/ovf stay stable while out_valid && !out_ready. Results leave in acceptance order, with no loss and no duplication.
- Simultaneous events: the output handshake and a new input acceptance may occur in the same cycle. A full pipeline with out_ready = 1 keeps streaming.
- Reset mid-operation: all in-flight tokens are discarded and all outputs return to their reset values immediately, without waiting for a clock edge. After rst deasserts, the first acceptance is possible at the next rising edge.
- Wrap-around: the sum wraps modulo 2^WIDTH; the carry-out is reported on co only.
- s/co/ovf contents when out_valid = 0 are don't-care for checking, but the datapath must not produce X after reset.

Test Plan:
1. Default parameters, a=520, b=10, ci=1, sub=0, out_ready=1 -> s=531, co=0, ovf=0, with out_valid rising exactly 4 cycles after acceptance.
2. Full carry chain across all chunks:
   - a=32'hFFFFFFFF, b=0, ci=1 -> s=0, co=1, ovf=0.
   - a=32'h7FFFFFFF, b=1, ci=0 -> s=32'h80000000, co=0, ovf=1.
3. Subtract mode:
   - a=100, b=200, sub=1, ci=1 (ignored) -> s=32'hFFFFFF9C, co=0, ovf=0.
   - a=200, b=100, sub=1 -> s=100, co=1.
4. Streaming with backpressure:
   - Drive 8 back-to-back sets (37+48, 125+110+1, 63+211, ...).
   - Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 8 results in order with no drops or repeats.
5. Assert rst while 3 tokens are in flight -> out_valid=0 and s=0 immediately; after release, no stale results appear and the next add (3+90+1) returns 94 after 4 cycles.
6. Instance with WIDTH=8, STAGES=1, input 127+127+1 -> s=255, co=0, ovf=1, latency 1. Instance with WIDTH=16, STAGES=16, input 16'hFFFF+1 -> s=0, co=1, latency 16.
